// File: rtl/adc_pkg.sv
// Shared types for the AD9228 frame packer.
// Word layout, state encoding and field widths.
package adc_pkg;

  localparam int SAMPLE_BITS = 12;
  localparam int CH_ID_BITS  = 4;
  localparam int WORD_BITS   = CH_ID_BITS + SAMPLE_BITS;

  typedef struct packed {
    logic [CH_ID_BITS-1:0]  ch_id;
    logic [SAMPLE_BITS-1:0] sample;
  } adc_word_t;

  typedef enum logic {
    IDLE,
    EMIT
  } packer_state_t;

endpackage

// File: rtl/adc_frame_packer_if.sv
// Output word stream of the frame packer.
// Valid/ready handshake; last marks the final word of a frame.
interface adc_frame_packer_if;
  import adc_pkg::*;

  adc_word_t data;
  logic      last;
  logic      valid;
  logic      ready;

  modport master (
    output data,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  last,
    input  valid,
    output ready
  );

endinterface

// File: rtl/adc_frame_packer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Reports occupancy so writers can reserve space ahead of time.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             full;
  logic             wr;
  logic             rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  // Hold zero on the output while empty.
  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs enabled channels of each ADC frame into tagged words.
// Whole frames only: space is reserved at accept or the frame is dropped.
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int SAMPLE_BITS  = 12,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [NUM_CHANNELS-1:0]            channel_mask,
  input  logic                               frame_valid,
  input  logic [NUM_CHANNELS*SAMPLE_BITS-1:0] frame_data,
  adc_frame_packer_if.master                 m,
  output logic [31:0]                        frame_count,
  output logic [15:0]                        drop_count
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = CH_ID_BITS;

  packer_state_t state_q, state_d;

  logic [NUM_CHANNELS*SAMPLE_BITS-1:0] sh_data;
  logic [NUM_CHANNELS-1:0]            sh_mask;
  logic [IW-1:0]                      ch_idx, idx_d;
  logic [IW-1:0]                      low_idx, nxt_idx;
  logic                               nxt_found;
  logic [OW-1:0]                      need, occ, free;
  logic                               accept, drop;
  logic                               push, push_last;
  adc_word_t                          word;
  logic [WORD_BITS:0]                 fifo_rd;
  logic                               empty;

  always_comb begin
    need    = '0;
    low_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      need = need + OW'(channel_mask[i]);
      if (channel_mask[i]) low_idx = IW'(i);
    end
  end

  // Lowest set shadow bit strictly above the current channel.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = ch_idx;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (sh_mask[i] && (i > int'(ch_idx))) begin
        nxt_found = 1'b1;
        nxt_idx   = IW'(i);
      end
    end
  end

  assign free        = OW'(FIFO_DEPTH) - occ;
  assign word.ch_id  = ch_idx;
  assign word.sample =
    sh_data[int'(ch_idx)*SAMPLE_BITS +: SAMPLE_BITS];

  always_comb begin
    state_d   = state_q;
    idx_d     = ch_idx;
    accept    = 1'b0;
    drop      = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_valid && enable && (|channel_mask)) begin
          if (free >= need) begin
            accept  = 1'b1;
            idx_d   = low_idx;
            state_d = EMIT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      EMIT: begin
        push      = 1'b1;
        push_last = ~nxt_found;
        idx_d     = nxt_idx;
        drop      = frame_valid;
        if (!nxt_found) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_idx      <= '0;
      sh_data     <= '0;
      sh_mask     <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      state_q <= state_d;
      ch_idx  <= idx_d;
      if (accept) begin
        sh_data     <= frame_data;
        sh_mask     <= channel_mask;
        frame_count <= frame_count + 32'd1;
      end
      if (drop && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({push_last, word}),
    .pop   (m.valid & m.ready),
    .rdata (fifo_rd),
    .empty (empty),
    .count (occ)
  );

  assign m.valid        = ~empty;
  assign {m.last, m.data} = fifo_rd;

endmodule
